// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and stall sequencer for ID, with taken-branch IF/ID flush and saturating event counters.
// RUN outputs are Mealy from the ID/producer inputs; STALL outputs are Moore.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rn,
    input  logic [4:0]       ID_Rm,
    input  logic [4:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic             ID_early,
    input  logic             ID_taken,
    input  logic [4:0]       IDEX_Rd,
    input  logic [4:0]       EXMEM_Rd,
    input  logic             IDEX_RegWrite,
    input  logic             EXMEM_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_MemRead,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic {RUN, STALL} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             idex_hit, exmem_hit;
    logic [1:0]       need_n;

    // Only loads can hazard; X31 is the zero register and never carries a dependency.
    function automatic logic load_hit(input logic [4:0] prd, input logic rw, input logic mr);
        return rw && mr && (prd != 5'd31) &&
               ((ID_use_Rn && (ID_Rn == prd)) ||
                (ID_use_Rm && (ID_Rm == prd)) ||
                (ID_use_Rd && (ID_Rd == prd)));
    endfunction

    assign idex_hit  = load_hit(IDEX_Rd, IDEX_RegWrite, IDEX_MemRead);
    assign exmem_hit = load_hit(EXMEM_Rd, EXMEM_RegWrite, EXMEM_MemRead);

    always_comb begin
        need_n = 2'd0;
        if (ID_early) begin
            if (idex_hit)       need_n = 2'd2;
            else if (exmem_hit) need_n = 2'd1;
        end else if (idex_hit) begin
            need_n = 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b1;
        IFID_flush  = 1'b0;
        stalling    = 1'b0;
        if (reset) begin
            IFID_flush = 1'b1;
            state_d    = RUN;
            cnt_d      = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (need_n == 2'd0) begin
                        PC_write    = 1'b1;
                        IFID_write  = 1'b1;
                        IDEX_bubble = 1'b0;
                        IFID_flush  = ID_taken;
                    end else if (need_n == 2'd2) begin
                        state_d = STALL;
                        cnt_d   = 2'd1;
                    end
                end
                STALL: begin
                    stalling = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    if (cnt_d == 2'd0) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!PC_write && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (IFID_flush && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios, a per-cycle reference model, and literal spot checks.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rn, ID_Rm, ID_Rd, IDEX_Rd, EXMEM_Rd;
    logic       ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_early, ID_taken;
    logic       IDEX_RegWrite, EXMEM_RegWrite, IDEX_MemRead, EXMEM_MemRead;

    logic        pcw_a, ifw_a, bub_a, fl_a, stl_a;
    logic [15:0] sc_a, fc_a;
    logic        pcw_b, ifw_b, bub_b, fl_b, stl_b;
    logic [1:0]  sc_b, fc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .ID_early(ID_early), .ID_taken(ID_taken),
        .IDEX_Rd(IDEX_Rd), .EXMEM_Rd(EXMEM_Rd),
        .IDEX_RegWrite(IDEX_RegWrite), .EXMEM_RegWrite(EXMEM_RegWrite),
        .IDEX_MemRead(IDEX_MemRead), .EXMEM_MemRead(EXMEM_MemRead),
        .PC_write(pcw_a), .IFID_write(ifw_a), .IDEX_bubble(bub_a),
        .IFID_flush(fl_a), .stalling(stl_a),
        .stall_cycles(sc_a), .flush_cycles(fc_a)
    );

    hazard_stall_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .ID_early(ID_early), .ID_taken(ID_taken),
        .IDEX_Rd(IDEX_Rd), .EXMEM_Rd(EXMEM_Rd),
        .IDEX_RegWrite(IDEX_RegWrite), .EXMEM_RegWrite(EXMEM_RegWrite),
        .IDEX_MemRead(IDEX_MemRead), .EXMEM_MemRead(EXMEM_MemRead),
        .PC_write(pcw_b), .IFID_write(ifw_b), .IDEX_bubble(bub_b),
        .IFID_flush(fl_b), .stalling(stl_b),
        .stall_cycles(sc_b), .flush_cycles(fc_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_hold = 0;            // forced stall cycles still owed regardless of inputs
    int  m_sc16 = 0, m_fc16 = 0, m_sc2 = 0, m_fc2 = 0;
    bit  m_known = 0;           // counters defined once a reset edge has been seen

    // Required stall for the ID instruction: worst case over both producers.
    function automatic int need_stall();
        int n = 0;
        logic [4:0] prd [2];
        bit         ld  [2];
        int         ahead;
        prd[0] = IDEX_Rd;  ld[0] = IDEX_RegWrite  && IDEX_MemRead;
        prd[1] = EXMEM_Rd; ld[1] = EXMEM_RegWrite && EXMEM_MemRead;
        for (int p = 0; p < 2; p++) begin
            bit dep = (ID_use_Rn && ID_Rn == prd[p]) || (ID_use_Rm && ID_Rm == prd[p]) ||
                      (ID_use_Rd && ID_Rd == prd[p]);
            if (ld[p] && dep && prd[p] != 5'd31) begin
                // distance in cycles until the loaded value can be forwarded to the consumer
                ahead = ID_early ? 2 - p : 1 - p;
                if (ahead > n) n = ahead;
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        bit e_pc, e_ifw, e_bub, e_fl, e_stl;
        int n;
        n = need_stall();
        if (reset) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 1; e_stl = 0;
        end else if (m_hold > 0) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_stl = 1;
        end else if (n == 0) begin
            e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = ID_taken; e_stl = 0;
        end else begin
            e_pc = 0; e_ifw = 0; e_bub = 1; e_fl = 0; e_stl = 0;
        end
        chk("PC_write",    pcw_a, e_pc);
        chk("IFID_write",  ifw_a, e_ifw);
        chk("IDEX_bubble", bub_a, e_bub);
        chk("IFID_flush",  fl_a,  e_fl);
        chk("stalling",    stl_a, e_stl);
        chk("sat_PC_write", pcw_b, e_pc);
        chk("sat_stalling", stl_b, e_stl);
        if (m_known) begin
            chk("stall_cycles",     sc_a, m_sc16);
            chk("flush_cycles",     fc_a, m_fc16);
            chk("sat_stall_cycles", sc_b, m_sc2);
            chk("sat_flush_cycles", fc_b, m_fc2);
        end
        // state that the coming rising edge will establish
        if (reset) begin
            m_hold = 0; m_sc16 = 0; m_fc16 = 0; m_sc2 = 0; m_fc2 = 0; m_known = 1;
        end else begin
            if (m_hold > 0)  m_hold--;
            else if (n == 2) m_hold = 1;
            if (!e_pc) begin
                if (m_sc16 < 65535) m_sc16++;
                if (m_sc2 < 3)      m_sc2++;
            end
            if (e_fl) begin
                if (m_fc16 < 65535) m_fc16++;
                if (m_fc2 < 3)      m_fc2++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic set_id(input int rn, input int rm, input bit urn, input bit urm,
                          input bit early, input bit taken);
        ID_Rn = 5'(rn); ID_Rm = 5'(rm); ID_Rd = 5'd0;
        ID_use_Rn = urn; ID_use_Rm = urm; ID_use_Rd = 1'b0;
        ID_early = early; ID_taken = taken;
    endtask

    task automatic set_prod(input int xrd, input bit xrw, input bit xmr,
                            input int mrd, input bit mrw, input bit mmr);
        IDEX_Rd = 5'(xrd);  IDEX_RegWrite = xrw;  IDEX_MemRead = xmr;
        EXMEM_Rd = 5'(mrd); EXMEM_RegWrite = mrw; EXMEM_MemRead = mmr;
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
        set_prod(0, 0, 0, 0, 0, 0);
        tick(); tick();
        mid();
        chk("lit_reset_pc",    pcw_a, 0);
        chk("lit_reset_bub",   bub_a, 1);
        chk("lit_reset_flush", fl_a,  1);
        chk("lit_reset_stl",   stl_a, 0);
        tick();
        reset = 1'b0;
        mid();
        chk("lit_post_reset_sc", sc_a, 0);
        chk("lit_post_reset_fc", fc_a, 0);

        // no hazard: producer in EX writes X3 but is not a load
        set_id(3, 0, 1, 0, 0, 0);
        set_prod(3, 1, 0, 0, 0, 0);
        mid();
        chk("lit_nohaz_pc",  pcw_a, 1);
        chk("lit_nohaz_bub", bub_a, 0);
        tick();
        chk("lit_nohaz_sc", sc_a, 0);

        // normal load-use: one stall, then the load sits in MEM and is forwarded
        set_id(0, 5, 0, 1, 0, 0);
        set_prod(5, 1, 1, 0, 0, 0);
        mid();
        chk("lit_lu_pc", pcw_a, 0);
        tick();
        chk("lit_lu_sc", sc_a, 1);
        set_prod(0, 0, 0, 5, 1, 1);
        mid();
        chk("lit_lu_pc2", pcw_a, 1);
        tick();

        // early branch behind a load of X30: two stalls, then taken flush
        set_id(30, 0, 1, 0, 1, 0);
        set_prod(30, 1, 1, 0, 0, 0);
        mid();
        chk("lit_br_stl1", stl_a, 0);
        tick();
        set_id(30, 0, 1, 0, 1, 1);          // taken during STALL must not flush
        set_prod(0, 0, 0, 30, 1, 1);
        mid();
        chk("lit_br_stl2",   stl_a, 1);
        chk("lit_br_noflush", fl_a, 0);
        tick();
        set_prod(0, 0, 0, 0, 0, 0);
        mid();
        chk("lit_br_flush", fl_a, 1);
        tick();
        chk("lit_br_fc", fc_a, 1);
        chk("lit_br_sc", sc_a, 3);
        set_id(0, 0, 0, 0, 0, 0);

        // X31 load never hazards
        set_id(31, 0, 1, 0, 1, 0);
        set_prod(31, 1, 1, 31, 1, 1);
        mid();
        chk("lit_xzr_pc", pcw_a, 1);
        tick();

        // loads of X7 in both producers, early consumer: n = 2
        set_id(7, 0, 1, 0, 1, 0);
        set_prod(7, 1, 1, 7, 1, 1);
        tick();
        mid();
        chk("lit_both_stl", stl_a, 1);
        tick();
        set_prod(0, 0, 0, 0, 0, 0);
        tick();

        // reset in the middle of STALL
        set_id(9, 0, 1, 0, 1, 0);
        set_prod(9, 1, 1, 0, 0, 0);
        tick();
        reset = 1'b1;
        mid();
        chk("lit_rst_stl",   stl_a, 0);
        chk("lit_rst_flush", fl_a,  1);
        tick();
        reset = 1'b0;
        set_prod(0, 0, 0, 0, 0, 0);
        mid();
        chk("lit_rst_sc", sc_a, 0);
        chk("lit_rst_fc", fc_a, 0);
        chk("lit_rst_run", pcw_a, 1);
        tick();

        // continuous hazard for 6 cycles: 2-bit counter pins at 3
        set_id(4, 0, 1, 0, 0, 0);
        set_prod(4, 1, 1, 0, 0, 0);
        repeat (6) tick();
        chk("lit_sat_sc", sc_b, 3);
        chk("lit_wide_sc", sc_a, 6);
        tick();
        chk("lit_sat_sc_hold", sc_b, 3);

        // repeated taken branches saturate the 2-bit flush counter
        set_prod(0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        chk("lit_sat_fc", fc_b, 3);
        chk("lit_wide_fc", fc_a, 5);
        set_id(0, 0, 0, 0, 0, 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
